supply_hub: RTL

SUPPLY_HUB -- requirements
Module: supply_hub

---
 rtl/supply_hub_pkg.sv | 29 ++
 rtl/supply_unit.sv | 107 ++++++++++
 rtl/supply_hub.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/supply_hub_pkg.sv
// Shared definitions for the supply hub: unit FSM states, delivery item
// codes, initial stock level and the base WORK latency.
package supply_hub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WORK = 2'd1,
    ST_DONE = 2'd2
  } unit_state_e;

  localparam logic [1:0] ITEM_PEACH      = 2'd0;
  localparam logic [1:0] ITEM_APPLE      = 2'd1;
  localparam logic [1:0] ITEM_FRIED_RICE = 2'd2;
  localparam logic [1:0] ITEM_NUGGET     = 2'd3;

  localparam logic [8:0] STOCK_INIT = 9'd300;
  localparam logic [3:0] BASE_LAT   = 4'd2;

  // Number of WORK cycles for a requested quantity: 2 + (number >> 3).
  function automatic logic [3:0] work_cycles(input logic [5:0] number);
    return BASE_LAT + {1'b0, number[5:3]};
  endfunction

  // Delivery code: kitchen items occupy codes 3/2, refrigerator items 1/0.
  function automatic logic [1:0] item_code(input logic is_refri, input logic product);
    return {~is_refri, product};
  endfunction

endpackage

// File: rtl/supply_unit.sv
// One restock unit (kitchen or refrigerator): IDLE -> WORK -> DONE -> IDLE.
// Handshake: a request is taken on a clk edge where valid_i=1 and ready_o=1;
// ready_o is a flop that is 1 exactly while the unit sits in IDLE, and
// valid_i is ignored whenever ready_o=0. The unit leaves DONE only on the
// cycle the hub grants it the shared delivery port (grant_i=1).
// Holds the two stock counters for its items (hi = product 1, lo = product 0).
module supply_unit
  import supply_hub_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              product_i,
  input  logic [5:0]        number_i,
  input  logic              grant_i,
  output logic              ready_o,
  output logic              product_o,
  output logic [5:0]        granted_o,
  output logic              shortage_o,
  output unit_state_e       state_o
);

  unit_state_e state_q, state_d;
  logic        ready_q;
  logic [3:0]  cnt_q, cnt_d;
  logic        product_q, product_d;
  logic [5:0]  number_q, number_d;
  logic [5:0]  granted_q, granted_d;
  logic        shortage_q, shortage_d;
  logic [8:0]  stock_hi_q, stock_hi_d;
  logic [8:0]  stock_lo_q, stock_lo_d;
  logic [8:0]  num_ext;
  logic [8:0]  stock_sel;
  logic [8:0]  grant_ext;

  // Next-state logic: latch request, count WORK cycles, settle stock on WORK exit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    product_d  = product_q;
    number_d   = number_q;
    granted_d  = granted_q;
    shortage_d = shortage_q;
    stock_hi_d = stock_hi_q;
    stock_lo_d = stock_lo_q;
    num_ext    = {3'b000, number_q};
    stock_sel  = product_q ? stock_hi_q : stock_lo_q;
    grant_ext  = (num_ext < stock_sel) ? num_ext : stock_sel;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          product_d = product_i;
          number_d  = number_i;
          cnt_d     = work_cycles(number_i) - 4'd1;
          state_d   = ST_WORK;
        end
      end
      ST_WORK: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_DONE;
          granted_d  = grant_ext[5:0];
          shortage_d = (grant_ext < num_ext);
          if (product_q) stock_hi_d = stock_hi_q - grant_ext;
          else           stock_lo_d = stock_lo_q - grant_ext;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (grant_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      cnt_q      <= 4'd0;
      product_q  <= 1'b0;
      number_q   <= 6'd0;
      granted_q  <= 6'd0;
      shortage_q <= 1'b0;
      stock_hi_q <= STOCK_INIT;
      stock_lo_q <= STOCK_INIT;
    end else begin
      state_q    <= state_d;
      ready_q    <= (state_d == ST_IDLE);
      cnt_q      <= cnt_d;
      product_q  <= product_d;
      number_q   <= number_d;
      granted_q  <= granted_d;
      shortage_q <= shortage_d;
      stock_hi_q <= stock_hi_d;
      stock_lo_q <= stock_lo_d;
    end
  end

  assign ready_o    = ready_q;
  assign product_o  = product_q;
  assign granted_o  = granted_q;
  assign shortage_o = shortage_q;
  assign state_o    = state_q;

endmodule

// File: rtl/supply_hub.sv
// Supply hub top: kitchen and refrigerator units sharing one registered
// delivery port. Kitchen wins when both units are in DONE together; the
// refrigerator then delivers on the following cycle.
// Optional statistics outputs are enabled with macro SUPPLY_HUB_STATS_EN.
module supply_hub
  import supply_hub_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_kitch,
  input  logic       valid_refri,
  input  logic       product_out,
  input  logic [5:0] number_out,
  output logic       ready_kitch,
  output logic       ready_refri,
  output logic       deliver_valid,
  output logic [1:0] deliver_product,
  output logic [5:0] deliver_number,
  output logic       shortage
`ifdef SUPPLY_HUB_STATS_EN
  ,
  output logic [11:0] delivered_total,
  output logic [7:0]  req_dropped
`endif
);

  unit_state_e ku_state, ru_state;
  logic        ku_prod, ru_prod;
  logic [5:0]  ku_granted, ru_granted;
  logic        ku_short, ru_short;
  logic        ku_done, ru_done;
  logic        grant_k, grant_r;

  logic        dv_q, dv_d;
  logic [1:0]  prod_q, prod_d;
  logic [5:0]  num_q, num_d;
  logic        sh_q, sh_d;

  supply_unit u_kitch (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_kitch),
    .product_i  (product_out),
    .number_i   (number_out),
    .grant_i    (grant_k),
    .ready_o    (ready_kitch),
    .product_o  (ku_prod),
    .granted_o  (ku_granted),
    .shortage_o (ku_short),
    .state_o    (ku_state)
  );

  supply_unit u_refri (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_refri),
    .product_i  (product_out),
    .number_i   (number_out),
    .grant_i    (grant_r),
    .ready_o    (ready_refri),
    .product_o  (ru_prod),
    .granted_o  (ru_granted),
    .shortage_o (ru_short),
    .state_o    (ru_state)
  );

  assign ku_done = (ku_state == ST_DONE);
  assign ru_done = (ru_state == ST_DONE);
  assign grant_k = ku_done;
  assign grant_r = ru_done & ~ku_done;

  // Arbitration and next delivery payload; payload is zero when nothing delivers.
  always_comb begin
    dv_d   = 1'b0;
    prod_d = 2'd0;
    num_d  = 6'd0;
    sh_d   = 1'b0;
    if (grant_k) begin
      dv_d   = 1'b1;
      prod_d = item_code(1'b0, ku_prod);
      num_d  = ku_granted;
      sh_d   = ku_short;
    end else if (grant_r) begin
      dv_d   = 1'b1;
      prod_d = item_code(1'b1, ru_prod);
      num_d  = ru_granted;
      sh_d   = ru_short;
    end
  end

  // Delivery output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q   <= 1'b0;
      prod_q <= 2'd0;
      num_q  <= 6'd0;
      sh_q   <= 1'b0;
    end else begin
      dv_q   <= dv_d;
      prod_q <= prod_d;
      num_q  <= num_d;
      sh_q   <= sh_d;
    end
  end

  assign deliver_valid   = dv_q;
  assign deliver_product = prod_q;
  assign deliver_number  = num_q;
  assign shortage        = sh_q;

`ifdef SUPPLY_HUB_STATS_EN
  logic [11:0] total_q, total_d;
  logic [7:0]  dropped_q, dropped_d;
  logic [12:0] total_sum;
  logic [8:0]  drop_sum;

  // Saturating counters: delivered quantity and requests ignored while busy.
  always_comb begin
    total_sum = {1'b0, total_q} + {7'd0, num_d};
    drop_sum  = {1'b0, dropped_q} + {8'd0, valid_kitch & ~ready_kitch}
                                  + {8'd0, valid_refri & ~ready_refri};
    total_d   = total_sum[12] ? 12'hFFF : total_sum[11:0];
    dropped_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q   <= 12'd0;
      dropped_q <= 8'd0;
    end else begin
      total_q   <= total_d;
      dropped_q <= dropped_d;
    end
  end

  assign delivered_total = total_q;
  assign req_dropped     = dropped_q;
`endif

endmodule
